wvl_conv_center_loader: RTL and testbench
=========================================

# wvl_conv_center_loader

Loads per-channel phase centers from the 32-bit `load_centers` software register into a 2048-entry center table. It applies those centers to the channelized phase stream by subtracting the center of each sample's channel. It sits in the `user_clk` domain of the wavelength-conversion phase-3 stage: downstream of the PPC-to-Simulink register and upstream of the phase-to-energy lookup.

## Interface
Parameters:
- `PHASE_W`, 16: signed phase sample and center width.
- `CHAN_W`, 11: channel index width (2048 channels).

Ports:
- `user_clk` in 1: single clock for all logic.
- `user_rst_n` in 1: asynchronous, active-low reset.
- `load_reg` in 32: register word.
  - [31] load strobe.
  - [30] clear request.
  - [26:16] channel.
  - [15:0] center (two's complement).
- `valid_in` in 1: input sample valid.
- `chan_in` in `CHAN_W`: channel of input sample.
- `phase_in` in `PHASE_W`: signed phase.
- `valid_out` out 1: output valid; reset 0.
- `chan_out` out `CHAN_W`: channel, delayed; reset 0.
- `phase_out` out `PHASE_W`: `phase_in - center`; reset 0.
- `busy` out 1: clear sweep running; reset 1.
- `load_count` out 16: committed center writes, wraps at 65535→0; reset 0.
- `load_drop` out 1: sticky, a load edge was discarded; reset 0; cleared only by reset or a clear request.

## Operation
- `load_reg` passes through two register stages: `q1`, then `q2`.
- Load event: `q1[31] & ~q2[31]`.
  - `q2[31]` resets to 1, so a strobe held high through reset never loads.
- Clear event: `q1[30] & ~q2[30]`; `q2[30]` resets to 1.
- FSM states:
  - IDLE: a load event writes `q1[15:0]` to table[`q1[26:16]`] on the next edge and increments `load_count`. A clear event moves to CLEAR with `addr=0` and clears `load_drop`.
  - CLEAR: writes 0 to table[`addr`] each cycle and increments `addr`. When the write to `addr=2047` completes, returns to IDLE. `busy`=1 throughout.
- Reset enters CLEAR at `addr=0`; table contents are never assumed valid after power-up.
- A load event in CLEAR is dropped and sets `load_drop`; `load_count` is unchanged. A clear event in CLEAR is ignored.
- Simultaneous load and clear events in IDLE: the load commits, then CLEAR starts the next cycle. Net effect: all entries are 0, `load_count` +1.
- Stream path: three-stage pipeline.
  1. Register `chan_in`, `phase_in`, `valid_in`; drive the RAM read address.
  2. RAM read data registered.
  3. Subtract, register the result.
- While any stage-2 sample was read during `busy`=1, its center is forced to 0.
- Subtraction is done at `PHASE_W+1` bits, then reduced per Configuration.
- The table is simple dual-port, read-first: a read and write to the same address on the same edge returns the old value.
- Reset mid-sweep restarts CLEAR from `addr=0`; in-flight pipeline stages drop (`valid_out`=0).

## Timing
- Latency: `valid_in`/`chan_in`/`phase_in` at edge t → `valid_out`/`chan_out`/`phase_out` at edge t+3. Throughput is 1 sample/cycle with no stalls and no backpressure.
- Load commit: load bit first high at edge k → `q1` at k+1, RAM write and `load_count` update at k+2. A stream RAM read at edge ≥ k+3 sees the new center.
- Clear sweep: exactly 2048 cycles. `busy` falls on the edge after the last write.
- After reset deassertion, `busy` stays 1 for 2048 cycles.
- Consecutive loads need the strobe low for ≥1 sampled cycle between edges.

## Configuration
- `WVL_CENTER_SAT_EN` defined: the `PHASE_W+1`-bit difference saturates to `[-2^(PHASE_W-1), 2^(PHASE_W-1)-1]`.
- `WVL_CENTER_SAT_EN` undefined: the low `PHASE_W` bits are kept (modulo wrap, natural for phase).

## Structure
- Shared package `wvl_conv_pkg`:
  - `load_reg` bit-field position constants (`LOAD_BIT`, `CLEAR_BIT`, `CHAN_LSB`, `CHAN_MSB`, `CENTER_LSB`).
  - FSM state typedef {IDLE, CLEAR}.
  - `NUM_CHAN=2048`.
- One sub-module: `wvl_center_ram`, a simple dual-port read-first RAM with registered read, depth 2^`CHAN_W`, width `PHASE_W`. The FSM and the pipeline live in the top.

## Test plan
- Reset, then hold `valid_in`=1, `chan_in`=5, `phase_in`=100:
  - `busy`=1 for 2048 cycles.
  - `phase_out`=100 throughout, and after.
  - `load_count`=0.
- After clear, write `load_reg`=0x8005_0064, then 0x0005_0064:
  - `load_count`=1.
  - A chan-5 sample with `phase_in`=300 gives `phase_out`=200 three cycles later.
  - A chan-6 sample is unchanged.
- Center 0x7FFF on chan 3, `phase_in`=-32768:
  - with `WVL_CENTER_SAT_EN`: `phase_out`=-32768;
  - without: `phase_out`=1.
- Load strobe pulsed during a clear sweep:
  - `load_drop`=1, `load_count` unchanged.
  - After the sweep, table[chan] = 0.
- Chan-9 stream read on the same edge as the chan-9 write of 50:
  - that sample uses the old center;
  - the next chan-9 sample uses 50.
- `load_reg`=0x8000_0001 held high through reset:
  - no load after reset; `load_count`=0.

Source files
------------

// File: rtl/wvl_conv_pkg.sv
// Shared definitions for the wavelength-conversion phase-3 stage: load_reg
// field positions, channel count and the center-loader control state type.
package wvl_conv_pkg;

  localparam int LOAD_BIT   = 31;
  localparam int CLEAR_BIT  = 30;
  localparam int CHAN_LSB   = 16;
  localparam int CHAN_MSB   = 26;
  localparam int CENTER_LSB = 0;

  localparam int NUM_CHAN = 2048;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctl_state_e;

endpackage

// File: rtl/wvl_center_ram.sv
// Simple dual-port center table: one write port, one registered read port,
// read-first on a same-address collision.
module wvl_center_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; its contents are
  // made valid by the clear sweep the controller runs after every reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wvl_conv_center_loader.sv
// Per-channel phase center table loaded from a software register, subtracted
// from the channelized phase stream. Define WVL_CENTER_SAT_EN to saturate the
// difference instead of wrapping it modulo 2^PHASE_W.
module wvl_conv_center_loader
  import wvl_conv_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int CHAN_W  = 11
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic [31:0]        load_reg,
  input  logic               valid_in,
  input  logic [CHAN_W-1:0]  chan_in,
  input  logic [PHASE_W-1:0] phase_in,
  output logic               valid_out,
  output logic [CHAN_W-1:0]  chan_out,
  output logic [PHASE_W-1:0] phase_out,
  output logic               busy,
  output logic [15:0]        load_count,
  output logic               load_drop
);

  localparam logic [CHAN_W-1:0] CLR_LAST = CHAN_W'(NUM_CHAN - 1);

  // Register word resynchronised through q1/q2; only the fields in use are kept.
  logic               q1_load, q1_clear, q2_load, q2_clear;
  logic [CHAN_W-1:0]  q1_chan;
  logic [PHASE_W-1:0] q1_center;
  logic               load_ev, clear_ev;

  ctl_state_e         state, state_nxt;
  logic [CHAN_W-1:0]  clr_addr;
  logic               commit, drop, clr_start;
  logic               ram_we;
  logic [CHAN_W-1:0]  ram_waddr;
  logic [PHASE_W-1:0] ram_wdata, ram_rdata;

  logic               s1_valid, s2_valid, s2_zero;
  logic [CHAN_W-1:0]  s1_chan, s2_chan;
  logic [PHASE_W-1:0] s1_phase, s2_phase, center, result;
  logic [PHASE_W:0]   diff;

  logic unused_reg_bits;
  assign unused_reg_bits = ^load_reg[CLEAR_BIT-1:CHAN_MSB+1];

  // Strobe history resets high so a bit held through reset yields no edge.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      q1_load   <= 1'b1;
      q1_clear  <= 1'b1;
      q2_load   <= 1'b1;
      q2_clear  <= 1'b1;
      q1_chan   <= '0;
      q1_center <= '0;
    end else begin
      q1_load   <= load_reg[LOAD_BIT];
      q1_clear  <= load_reg[CLEAR_BIT];
      q2_load   <= q1_load;
      q2_clear  <= q1_clear;
      q1_chan   <= load_reg[CHAN_LSB +: CHAN_W];
      q1_center <= load_reg[CENTER_LSB +: PHASE_W];
    end
  end

  assign load_ev  = q1_load & ~q2_load;
  assign clear_ev = q1_clear & ~q2_clear;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= CLEAR;
    else             state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_waddr = q1_chan;
    ram_wdata = q1_center;
    commit    = 1'b0;
    drop      = 1'b0;
    clr_start = 1'b0;
    case (state)
      IDLE: begin
        // A load and a clear on the same cycle: the load lands, then the sweep erases it.
        if (load_ev) begin
          ram_we = 1'b1;
          commit = 1'b1;
        end
        if (clear_ev) begin
          state_nxt = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = '0;
        drop      = load_ev;
        if (clr_addr == CLR_LAST) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      clr_addr   <= '0;
      load_count <= '0;
      load_drop  <= 1'b0;
    end else begin
      if (clr_start)           clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + CHAN_W'(1);
      if (commit) load_count <= load_count + 16'd1;
      if (clr_start) load_drop <= 1'b0;
      else if (drop) load_drop <= 1'b1;
    end
  end

  assign busy = (state == CLEAR);

  wvl_center_ram #(
    .ADDR_W (CHAN_W),
    .DATA_W (PHASE_W)
  ) u_ram (
    .clk     (user_clk),
    .we      (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (s1_chan),
    .rd_data (ram_rdata)
  );

  // Reads taken while the sweep runs see a half-cleared table; treat them as zero.
  assign center = s2_zero ? '0 : ram_rdata;
  assign diff   = {s2_phase[PHASE_W-1], s2_phase} - {center[PHASE_W-1], center};

`ifdef WVL_CENTER_SAT_EN
  always_comb begin
    result = diff[PHASE_W-1:0];
    if (diff[PHASE_W] != diff[PHASE_W-1])
      result = diff[PHASE_W] ? {1'b1, {(PHASE_W-1){1'b0}}} : {1'b0, {(PHASE_W-1){1'b1}}};
  end
`else
  logic unused_diff_msb;
  assign unused_diff_msb = diff[PHASE_W];
  assign result          = diff[PHASE_W-1:0];
`endif

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      s1_valid  <= 1'b0;
      s1_chan   <= '0;
      s1_phase  <= '0;
      s2_valid  <= 1'b0;
      s2_chan   <= '0;
      s2_phase  <= '0;
      s2_zero   <= 1'b0;
      valid_out <= 1'b0;
      chan_out  <= '0;
      phase_out <= '0;
    end else begin
      s1_valid  <= valid_in;
      s1_chan   <= chan_in;
      s1_phase  <= phase_in;
      s2_valid  <= s1_valid;
      s2_chan   <= s1_chan;
      s2_phase  <= s1_phase;
      s2_zero   <= busy;
      valid_out <= s2_valid;
      chan_out  <= s2_chan;
      phase_out <= result;
    end
  end

endmodule

// File: tb/tb_wvl_conv_center_loader.sv
// Self-checking bench for wvl_conv_center_loader: behavioural table model,
// directed vectors and randomized stream/register traffic.
module tb_wvl_conv_center_loader;

  localparam int PHASE_W = 16;
  localparam int CHAN_W  = 11;
  localparam int NCH     = 2048;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [31:0]        load_reg = '0;
  logic               valid_in = 1'b0;
  logic [CHAN_W-1:0]  chan_in = '0;
  logic [PHASE_W-1:0] phase_in = '0;
  logic               valid_out;
  logic [CHAN_W-1:0]  chan_out;
  logic [PHASE_W-1:0] phase_out;
  logic               busy;
  logic [15:0]        load_count;
  logic               load_drop;

  wvl_conv_center_loader #(.PHASE_W(PHASE_W), .CHAN_W(CHAN_W)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .load_reg   (load_reg),
    .valid_in   (valid_in),
    .chan_in    (chan_in),
    .phase_in   (phase_in),
    .valid_out  (valid_out),
    .chan_out   (chan_out),
    .phase_out  (phase_out),
    .busy       (busy),
    .load_count (load_count),
    .load_drop  (load_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit valid;
    int chan;
    int phase;
    int center;
  } msamp_t;

  int     m_tab [NCH];
  int     m_clear_left;
  int     m_count;
  bit     m_drop;
  bit     m_q1_load, m_q2_load, m_q1_clear, m_q2_clear;
  int     m_q1_chan, m_q1_center;
  msamp_t m_s1, m_s2;
  bit     e_valid;
  int     e_chan, e_phase;

  function automatic int reduce(input int d);
`ifdef WVL_CENTER_SAT_EN
    if (d > 32767)  return 32767;
    if (d < -32768) return -32768;
    return d;
`else
    logic signed [15:0] t;
    t = 16'(d);
    return int'(t);
`endif
  endfunction

  task automatic model_reset();
    m_clear_left = NCH;
    m_count      = 0;
    m_drop       = 1'b0;
    m_q1_load    = 1'b1;
    m_q2_load    = 1'b1;
    m_q1_clear   = 1'b1;
    m_q2_clear   = 1'b1;
    m_s1.valid   = 1'b0;
    m_s2.valid   = 1'b0;
    e_valid      = 1'b0;
  endtask

  // Advance one clock edge in both DUT and model, then compare.
  task automatic step();
    bit ev_load, ev_clear;
    @(posedge clk);
    e_valid = m_s2.valid;
    e_chan  = m_s2.chan;
    e_phase = reduce(m_s2.phase - m_s2.center);
    m_s2.valid  = m_s1.valid;
    m_s2.chan   = m_s1.chan;
    m_s2.phase  = m_s1.phase;
    m_s2.center = (m_clear_left > 0) ? 0 : m_tab[m_s1.chan];
    m_s1.valid  = valid_in;
    m_s1.chan   = int'(chan_in);
    m_s1.phase  = int'($signed(phase_in));
    ev_load  = m_q1_load && !m_q2_load;
    ev_clear = m_q1_clear && !m_q2_clear;
    if (m_clear_left > 0) begin
      m_tab[NCH - m_clear_left] = 0;
      m_clear_left--;
      if (ev_load) m_drop = 1'b1;
    end else begin
      if (ev_load) begin
        m_tab[m_q1_chan] = m_q1_center;
        m_count = (m_count + 1) % 65536;
      end
      if (ev_clear) begin
        m_clear_left = NCH;
        m_drop = 1'b0;
      end
    end
    m_q2_load   = m_q1_load;
    m_q2_clear  = m_q1_clear;
    m_q1_load   = load_reg[31];
    m_q1_clear  = load_reg[30];
    m_q1_chan   = int'(load_reg[26:16]);
    m_q1_center = int'($signed(load_reg[15:0]));
    #1;
    cyc++;
    check("busy", longint'(busy), longint'(m_clear_left > 0));
    check("load_count", longint'(load_count), longint'(m_count));
    check("load_drop", longint'(load_drop), longint'(m_drop));
    check("valid_out", longint'(valid_out), longint'(e_valid));
    if (e_valid) begin
      check("chan_out", longint'(chan_out), longint'(e_chan));
      check("phase_out", longint'($signed(phase_out)), longint'(e_phase));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid_out", longint'(valid_out), 0);
    check("rst_chan_out", longint'(chan_out), 0);
    check("rst_phase_out", longint'(phase_out), 0);
    check("rst_busy", longint'(busy), 1);
    check("rst_load_count", longint'(load_count), 0);
    check("rst_load_drop", longint'(load_drop), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2200 && busy; i++) step();
    check(name, longint'(busy), 0);
  endtask

  task automatic sample_check(input string name, input int ch, input int ph, input int exp);
    valid_in = 1'b1;
    chan_in  = 11'(ch);
    phase_in = 16'(ph);
    step();
    valid_in = 1'b0;
    step();
    step();
    check({name, "_valid"}, longint'(valid_out), 1);
    check(name, longint'($signed(phase_out)), longint'(exp));
  endtask

  task automatic pulse(input logic [31:0] w);
    load_reg = w;
    step();
    load_reg = w & 32'h3FFF_FFFF;
    step();
    step();
  endtask

  typedef struct {
    bit do_load;
    int chan;
    int center;
    int phase;
    int exp_wrap;
    int exp_sat;
  } vec_t;

  vec_t vecs [8];
  int   n_loads;
  int   busy_cycles;
  int   exp_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1,    5,    100,    300,    200,    200};
    vecs[1] = '{1'b0,    6,      0,    300,    300,    300};
    vecs[2] = '{1'b1,    3,  32767, -32768,      1, -32768};
    vecs[3] = '{1'b1,    7,     -5,     10,     15,     15};
    vecs[4] = '{1'b1,  100,   1000,  -1000,  -2000,  -2000};
    vecs[5] = '{1'b1, 2047, -32768,  32767,     -1,  32767};
    vecs[6] = '{1'b1,    0,      1, -32768,  32767, -32768};
    vecs[7] = '{1'b0,    5,      0,     -7,   -107,   -107};

    // Power-up sweep with a constant chan-5 stream.
    valid_in = 1'b1;
    chan_in  = 11'd5;
    phase_in = 16'd100;
    #2;
    do_reset();
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 3000 && busy; i++) begin
      step();
      if (busy) busy_cycles++;
      if (valid_out) check("hold_phase", longint'($signed(phase_out)), 100);
    end
    check("busy_cycles", longint'(busy_cycles), 2048);
    repeat (8) begin
      step();
      check("post_sweep_phase", longint'($signed(phase_out)), 100);
    end
    check("count_after_sweep", longint'(load_count), 0);
    valid_in = 1'b0;
    step();

    // Directed load/subtract vectors.
    n_loads = 0;
    foreach (vecs[i]) begin
      if (vecs[i].do_load) begin
        pulse({1'b1, 1'b0, 3'b000, 11'(vecs[i].chan), 16'(vecs[i].center)});
        n_loads++;
      end
`ifdef WVL_CENTER_SAT_EN
      exp_v = vecs[i].exp_sat;
`else
      exp_v = vecs[i].exp_wrap;
`endif
      sample_check($sformatf("vec%0d", i), vecs[i].chan, vecs[i].phase, exp_v);
    end
    check("count_after_vecs", longint'(load_count), longint'(n_loads));

    // Load strobe during a clear sweep is dropped.
    pulse(32'h4000_0000);
    check("clear_started", longint'(busy), 1);
    pulse(32'h8005_0064);
    check("drop_set", longint'(load_drop), 1);
    check("drop_count_same", longint'(load_count), longint'(n_loads));
    wait_idle("sweep1_done");
    check("drop_sticky", longint'(load_drop), 1);
    sample_check("drop_tab_zero", 5, 300, 300);

    // Stream read colliding with the chan-9 write sees the old center.
    load_reg = 32'h8009_0032;
    valid_in = 1'b1;
    chan_in  = 11'd9;
    phase_in = 16'd1000;
    step();
    load_reg = 32'h0009_0032;
    step();
    valid_in = 1'b0;
    step();
    check("collide_valid", longint'(valid_out), 1);
    check("collide_old", longint'($signed(phase_out)), 1000);
    step();
    check("collide_next_new", longint'($signed(phase_out)), 950);
    n_loads++;

    // Simultaneous load and clear: load counts, then everything is wiped.
    pulse(32'hC00A_0007);
    n_loads++;
    check("simul_count", longint'(load_count), longint'(n_loads));
    check("simul_drop_cleared", longint'(load_drop), 0);
    wait_idle("sweep2_done");
    sample_check("simul_tab10", 10, 20, 20);
    sample_check("simul_tab9", 9, 20, 20);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load_reg = {($urandom_range(3) == 0), ($urandom_range(400) == 0), 3'b000,
                  11'($urandom_range(15)), 16'($urandom)};
      valid_in = 1'($urandom);
      chan_in  = 11'($urandom_range(15));
      phase_in = 16'($urandom);
      step();
    end

    // Reset mid-sweep with the load strobe held high throughout.
    load_reg = 32'h4000_0000;
    valid_in = 1'b0;
    repeat (3) step();
    load_reg = 32'h0000_0000;
    repeat (50) step();
    load_reg = 32'h8000_0001;
    valid_in = 1'b1;
    chan_in  = 11'd1;
    phase_in = 16'd5;
    do_reset();
    step();
    check("held_busy_restart", longint'(busy), 1);
    for (int i = 0; i < 2100; i++) step();
    check("held_no_load", longint'(load_count), 0);
    check("held_phase", longint'($signed(phase_out)), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
